// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared ALU definitions for the iterative multiplier and divider
//
// Purpose: state encoding for the multiplier FSM, the default operand width
// shared with div, and a two's-complement magnitude helper used by both units.
// Ports: none (package).

package mul_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_FIX  = 2'd2,
    MUL_DONE = 2'd3
  } mul_state_e;

  // -2^(W-1) maps to 2^(W-1), which is still representable as an unsigned
  // W-bit value, so no extra bit is needed.
  function automatic logic [MUL_WIDTH-1:0] twos_mag(input logic [MUL_WIDTH-1:0] v,
                                                    input logic                 is_signed);
    return (is_signed && v[MUL_WIDTH-1]) ? (~v + MUL_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_addshift.sv
// rtl/mul_addshift.sv - one radix-2 step: conditional add into upper half, then shift right
//
// Purpose: combinational step of the shift-add multiplier.
// Ports:
//   acc         in   2*WIDTH  running accumulator
//   mcand       in   WIDTH    multiplicand magnitude
//   mplier      in   WIDTH    remaining multiplier bits (LSB is the current bit)
//   acc_next    out  2*WIDTH  accumulator after add and shift
//   mplier_next out  WIDTH    multiplier shifted right by one

module mul_addshift #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   mplier_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    // Carry out of the upper-half add is kept and becomes the new MSB after the shift.
    sum         = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next    = {sum, acc[WIDTH-1:1]};
    mplier_next = {1'b0, mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mul.sv
// rtl/mul.sv - sequential radix-2 shift-add multiplier, signed or unsigned
//
// Purpose: multiplies two WIDTH-bit operands in a fixed WIDTH+1 cycles after
// the accept edge, producing a 2*WIDTH-bit product; either half is readable.
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset
//   A        in   WIDTH  multiplicand, sampled on accept
//   B        in   WIDTH  multiplier, sampled on accept
//   start    in   1      begin operation; honoured only in IDLE or DONE
//   signctl  in   1      1 = two's complement operands, 0 = unsigned
//   high_out in   1      selects upper (1) or lower (0) product word, live
//   dout     out  WIDTH  selected product word
//   drdy     out  1      product valid until next accept or reset
//   busy     out  1      operation in progress

module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             start,
  input  logic             signctl,
  input  logic             high_out,
  output logic [WIDTH-1:0] dout,
  output logic             drdy,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  mul_state_e state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;
  logic               drdy_q, drdy_d;
  logic               busy_q, busy_d;

  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   mplier_step;

  mul_addshift #(.WIDTH(WIDTH)) u_addshift (
    .acc         (acc_q),
    .mcand       (mcand_q),
    .mplier      (mplier_q),
    .acc_next    (acc_step),
    .mplier_next (mplier_step)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    count_d   = count_q;
    neg_d     = neg_q;
    drdy_d    = drdy_q;
    busy_d    = busy_q;

    case (state_q)
      MUL_IDLE, MUL_DONE: begin
        if (start) begin
          mcand_d  = twos_mag(A, signctl);
          mplier_d = twos_mag(B, signctl);
          neg_d    = signctl & (A[WIDTH-1] ^ B[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          drdy_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = MUL_RUN;
        end
      end
      MUL_RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = MUL_FIX;
        end
      end
      MUL_FIX: begin
        // Sign is applied once, on the full product; a zero magnitude stays zero.
        product_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
        drdy_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = MUL_DONE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= MUL_IDLE;
      acc_q     <= '0;
      product_q <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      drdy_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      drdy_q    <= drdy_d;
      busy_q    <= busy_d;
    end
  end

  // Only the registered product feeds dout, so both words can be read in DONE
  // by flipping high_out without any extra cycles.
  assign dout = high_out ? product_q[2*WIDTH-1:WIDTH] : product_q[WIDTH-1:0];
  assign drdy = drdy_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mul.sv
// tb/tb_mul.sv - directed self-checking bench for the mul block

module tb_mul;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        start;
  logic        signctl;
  logic        high_out;
  logic [31:0] dout;
  logic        drdy;
  logic        busy;

  int n_checks;
  int n_fails;

  mul #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .start    (start),
    .signctl  (signctl),
    .high_out (high_out),
    .dout     (dout),
    .drdy     (drdy),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_words(input string tag, input logic [63:0] exp);
    high_out = 1'b0;
    #1;
    check({tag, " lo"}, {32'd0, dout}, {32'd0, exp[31:0]});
    high_out = 1'b1;
    #1;
    check({tag, " hi"}, {32'd0, dout}, {32'd0, exp[63:32]});
    high_out = 1'b0;
  endtask

  // Accept one operation, optionally poke a second start mid-RUN, then wait
  // for drdy and check latency plus both product words.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sc, input logic [63:0] exp, input int poke_at,
                        input logic [63:0] prev);
    int edges;
    @(negedge clk);
    A = a; B = b; signctl = sc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy after accept"}, {63'd0, busy}, 64'd1);
    check({tag, " drdy after accept"}, {63'd0, drdy}, 64'd0);
    edges = 0;
    while (drdy !== 1'b1 && edges < 45) begin
      if (poke_at != 0 && edges == poke_at) begin
        A = 32'd100; B = 32'd100; signctl = ~sc; start = 1'b1;
        high_out = 1'b0;
        #1;
        check({tag, " old result during RUN"}, {32'd0, dout}, {32'd0, prev[31:0]});
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " busy in DONE"}, {63'd0, busy}, 64'd0);
    read_words(tag, exp);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b0; A = '0; B = '0; start = 1'b0; signctl = 1'b0; high_out = 1'b0;
    #2;
    check("reset drdy", {63'd0, drdy}, 64'd0);
    check("reset busy", {63'd0, busy}, 64'd0);
    read_words("reset dout", 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op("u 7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0, 64'd0);
    run_op("u max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 64'd0);
    run_op("s -3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 64'd0);
    run_op("u fffffffd x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 0, 64'd0);
    run_op("s min x min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 64'd0);
    run_op("s min x 1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, 64'd0);
    run_op("s 0 x -1", 32'd0, 32'hFFFF_FFFF, 1'b1, 64'd0, 0, 64'd0);
    run_op("s -1 x -1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1, 0, 64'd0);
    // Previous result is 1; the poked start at RUN cycle 10 must be ignored.
    run_op("ignored start", 32'd7, 32'd6, 1'b0, 64'h2A, 10, 64'd1);
    // Accepting again straight from DONE.
    run_op("restart from DONE", 32'd1000, 32'd1000, 1'b0, 64'd1000000, 0, 64'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    A = 32'd9; B = 32'd9; signctl = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst drdy", {63'd0, drdy}, 64'd0);
    check("async rst busy", {63'd0, busy}, 64'd0);
    read_words("async rst dout", 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("after reset 2x3", 32'd2, 32'd3, 1'b0, 64'd6, 0, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
